mem_bus_arbiter: RTL and testbench

- Arbitrates and sequences the single shared memory bus (BUS/Memread/Memwrite/Addr) between two requesters: the CPU and a DMA/peripheral master.
- Sits between the masters and the external memory.
- Runs a per-transaction FSM with a configurable wait-state count.
- Returns read data and a one-cycle ack to the granted requester.

---
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU/DMA) arbiter and sequencer for a single shared memory bus with WAIT_CYCLES strobe length.
// Define ARB_FIXED_PRIO_EN for fixed CPU priority on ties; otherwise ties are resolved round-robin.
module mem_bus_arbiter #(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,

   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,

   inout  wire  [DW-1:0] BUS,
   output logic          Memread,
   output logic          Memwrite,
   output logic [AW-1:0] Addr,
   output logic          busy,
   output logic          owner
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   logic [1:0]    state;
   logic [3:0]    count;
   logic          we_q;
   logic [DW-1:0] wdata_q;

   logic          any_req;
   logic          grant_dma;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          start;
   logic          finish;

`ifndef ARB_FIXED_PRIO_EN
   logic          last_grant;
`endif

   // Winner selection; a lone requester always wins, ties go to the master that was not served last.
   always_comb begin
      any_req = cpu_req | dma_req;
`ifdef ARB_FIXED_PRIO_EN
      grant_dma = dma_req & ~cpu_req;
`else
      grant_dma = dma_req & (~cpu_req | ~last_grant);
`endif
      sel_we    = grant_dma ? dma_we    : cpu_we;
      sel_addr  = grant_dma ? dma_addr  : cpu_addr;
      sel_wdata = grant_dma ? dma_wdata : cpu_wdata;
   end

   assign start  = (state == IDLE) && any_req;
   assign finish = (state == ACCESS) && (count == 4'd0);
   assign busy   = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         count <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= ACCESS;
                  count <= CNT_LOAD;
               end
            end
            ACCESS: begin
               if (count == 4'd0) begin
                  state <= DONE;
               end else begin
                  count <= count - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The granted request is captured once, so the masters' inputs are ignored until the next IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Addr    <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         owner   <= 1'b0;
      end else if (start) begin
         Addr    <= sel_addr;
         we_q    <= sel_we;
         wdata_q <= sel_wdata;
         owner   <= grant_dma;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Memread  <= 1'b0;
         Memwrite <= 1'b0;
      end else if (start) begin
         Memread  <= ~sel_we;
         Memwrite <= sel_we;
      end else if (finish) begin
         Memread  <= 1'b0;
         Memwrite <= 1'b0;
      end
   end

   // Read data is sampled on the last strobe cycle, while memory is still driving the bus.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_ack   <= 1'b0;
         dma_ack   <= 1'b0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
      end else begin
         cpu_ack <= finish & ~owner;
         dma_ack <= finish & owner;
         if (finish && !we_q) begin
            if (owner) begin
               dma_rdata <= BUS;
            end else begin
               cpu_rdata <= BUS;
            end
         end
      end
   end

`ifndef ARB_FIXED_PRIO_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= 1'b1;
      end else if (state == DONE) begin
         last_grant <= owner;
      end
   end
`endif

   // Memwrite resets asynchronously, so the bus is released the moment reset asserts.
   assign BUS = Memwrite ? wdata_q : {DW{1'bz}};

`ifndef SYNTHESIS
   strobes_exclusive: assert property (@(posedge clk) disable iff (!rst) !(Memread && Memwrite));
   acks_exclusive:    assert property (@(posedge clk) disable iff (!rst) !(cpu_ack && dma_ack));
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed reset/read/write/contention/abort cases, then random traffic.
// Follows ARB_FIXED_PRIO_EN to pick the expected tie-break rule.
module tb_mem_bus_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int W  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          dma_req = 1'b0, dma_we = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic [DW-1:0] dma_wdata = '0;
   logic [DW-1:0] dma_rdata;
   logic          dma_ack;
   wire  [DW-1:0] bus;
   logic          memread, memwrite, busy, owner;
   logic [AW-1:0] addr;
   logic [DW-1:0] tb_bus_val;

   int tests = 0;
   int failures = 0;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   txn_t          cpu_q[$];
   txn_t          dma_q[$];
   logic [DW-1:0] model_rdata [2];
   bit            model_last = 1'b1;

   mem_bus_arbiter #(.DW(DW), .AW(AW), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .BUS(bus), .Memread(memread), .Memwrite(memwrite), .Addr(addr),
      .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   // Memory content is a fixed function of address; the bus rests at zero when nobody is reading.
   function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
      if (a == 32'h0000_0004) return 32'h2021_00E9;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   assign tb_bus_val = memread ? mem_read(addr) : '0;
   assign bus = memwrite ? {DW{1'bz}} : tb_bus_val;

   task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit m, input bit we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input bit drop_early);
      txn_t t;
      int   n;
      bit   got_ack;
      t.we = we;
      t.addr = a;
      t.wdata = d;
      if (m) begin
         dma_q.push_back(t);
         dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
      end else begin
         cpu_q.push_back(t);
         cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end
      n = 0;
      got_ack = 1'b0;
      while (!got_ack && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         got_ack = m ? dma_ack : cpu_ack;
         if (!got_ack && drop_early && (memread || memwrite) && owner == m) begin
            if (m) dma_req = 1'b0; else cpu_req = 1'b0;
         end
      end
      if (m) dma_req = 1'b0; else cpu_req = 1'b0;
      if (!got_ack) checkOutput(m ? "dma_ack_timeout" : "cpu_ack_timeout", '0, 1);
   endtask

   int   cycle_idx = 0;
   int   start_idx = 0;
   int   strobe_len = 0;
   bit   in_flight = 1'b0;
   bit   winner = 1'b0;
   bit   prev_cpu_req = 1'b0;
   bit   prev_dma_req = 1'b0;
   txn_t cur;

   // Monitor: infers each grant from the requests seen in the sampling cycle and checks it end to end.
   always @(negedge clk) begin : monitor
      bit            exp_w;
      bit            m;
      txn_t          t;
      logic [DW-1:0] exp_rd;
      if (!rst) begin
         checkOutput("reset_strobes", DW'({memread, memwrite}), '0);
         checkOutput("reset_addr", addr, '0);
         checkOutput("reset_bus", bus, '0);
         checkOutput("reset_flags", DW'({cpu_ack, dma_ack, busy, owner}), '0);
         checkOutput("reset_cpu_rdata", cpu_rdata, '0);
         checkOutput("reset_dma_rdata", dma_rdata, '0);
         in_flight = 1'b0;
         model_last = 1'b1;
         model_rdata[0] = '0;
         model_rdata[1] = '0;
      end else begin
         checkOutput("strobe_onehot", DW'(memread & memwrite), '0);
         checkOutput("ack_onehot", DW'(cpu_ack & dma_ack), '0);
         if ((memread || memwrite) && !in_flight) begin
            if (!prev_cpu_req && !prev_dma_req) checkOutput("request_present", '0, 1);
`ifdef ARB_FIXED_PRIO_EN
            exp_w = !prev_cpu_req;
`else
            exp_w = prev_cpu_req ? (prev_dma_req ? !model_last : 1'b0) : 1'b1;
`endif
            checkOutput("grant_owner", DW'(owner), DW'(exp_w));
            winner = exp_w;
            if ((exp_w ? dma_q.size() : cpu_q.size()) == 0) begin
               checkOutput("queue_nonempty", '0, 1);
               cur = '{we: 1'b0, addr: '0, wdata: '0};
            end else begin
               cur = exp_w ? dma_q[0] : cpu_q[0];
            end
            checkOutput("start_addr", addr, cur.addr);
            checkOutput("start_dir", DW'({memread, memwrite}), cur.we ? 1 : 2);
            checkOutput("busy_access", DW'(busy), 1);
            in_flight = 1'b1;
            start_idx = cycle_idx;
            strobe_len = 0;
         end
         if (memread || memwrite) strobe_len++;
         if (memwrite) checkOutput("bus_write", bus, cur.wdata);
         else checkOutput("bus_released", bus, tb_bus_val);
         if (cpu_ack || dma_ack) begin
            m = dma_ack;
            if (!in_flight) begin
               checkOutput("ack_expected", '0, 1);
            end else begin
               checkOutput("ack_owner", DW'(m), DW'(winner));
               checkOutput("strobe_len", DW'(strobe_len), W);
               checkOutput("ack_latency", DW'(cycle_idx - start_idx), W);
               checkOutput("busy_done", DW'(busy), 1);
               if ((m ? dma_q.size() : cpu_q.size()) == 0) begin
                  checkOutput("ack_queue_nonempty", '0, 1);
               end else begin
                  t = m ? dma_q.pop_front() : cpu_q.pop_front();
                  exp_rd = t.we ? model_rdata[m] : mem_read(t.addr);
                  checkOutput(m ? "dma_rdata" : "cpu_rdata", m ? dma_rdata : cpu_rdata, exp_rd);
                  checkOutput(m ? "cpu_rdata_kept" : "dma_rdata_kept",
                              m ? cpu_rdata : dma_rdata, model_rdata[!m]);
                  model_rdata[m] = exp_rd;
               end
               model_last = m;
               in_flight = 1'b0;
            end
         end else if (!in_flight) begin
            checkOutput("busy_idle", DW'(busy), 0);
         end
      end
      prev_cpu_req = cpu_req;
      prev_dma_req = dma_req;
      cycle_idx++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Requests held through reset; after release the CPU must win the first tie.
      fork
         applyStimulus(1'b0, 1'b0, 32'h0000_0004, '0, 1'b0);
         applyStimulus(1'b1, 1'b0, 32'h0000_0100, '0, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
         end
      join
      repeat (2) begin @(posedge clk); #1; end

      applyStimulus(1'b1, 1'b1, 32'h0000_007B, 32'hAC01_007B, 1'b0);

      fork
         begin
            applyStimulus(1'b0, 1'b0, 32'h0000_0040, '0, 1'b0);
            applyStimulus(1'b0, 1'b1, 32'h0000_0044, 32'h1111_2222, 1'b0);
         end
         begin
            applyStimulus(1'b1, 1'b0, 32'h0000_0080, '0, 1'b0);
            applyStimulus(1'b1, 1'b1, 32'h0000_0084, 32'h3333_4444, 1'b0);
         end
      join

      // Reset in the second write-strobe cycle; the held request must complete afterwards.
      fork
         applyStimulus(1'b0, 1'b1, 32'h0000_00C0, 32'hDEAD_BEEF, 1'b0);
         begin
            int n = 0;
            while (!memwrite && n < 50) begin @(posedge clk); #1; n++; end
            checkOutput("abort_reached_write", DW'(memwrite), 1);
            @(posedge clk);
            #2 rst = 1'b0;
            #1;
            checkOutput("abort_memwrite", DW'(memwrite), 0);
            checkOutput("abort_bus", bus, '0);
            checkOutput("abort_busy", DW'(busy), 0);
            checkOutput("abort_acks", DW'({cpu_ack, dma_ack}), 0);
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
         end
      join

      fork
         for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3) == 0);
         end
         for (int j = 0; j < 50; j++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3) == 0);
         end
      join

      repeat (5) @(posedge clk);
      checkOutput("cpu_queue_drained", DW'(cpu_q.size()), 0);
      checkOutput("dma_queue_drained", DW'(dma_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
